// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {S_IDLE, S_IRD, S_DRD} arb_state_t;

    localparam logic [3:0] WEB_IDLE = 4'b1111;
    localparam int         CNT_W    = 4;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// Saturating count of consecutive cycles the fetch port has been refused a grant.
module sram_arb_starve_cnt
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic starved
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign starved = (starve_cnt == CNT_MAX);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data ports with a 1-cycle return.
// Define SRAM_ARB_STARVE_GUARD_EN to add the fetch starvation guard; otherwise data has strict priority.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,

    input  logic              dm_req,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [3:0]        dm_we,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,

    output logic              sram_cs,
    output logic              sram_oe,
    output logic [3:0]        sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
    input  logic [DATA_W-1:0] sram_do
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_range
        $error("sram_port_arbiter: STARVE_MAX must be within 1..15");
    end

    arb_state_t state;
    logic       kill_q;
    logic       starved;
    logic       dm_rd;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    sram_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .starved (starved)
    );
`else
    assign starved = 1'b0;
`endif

    // Grants are held off while reset is asserted so the macro stays deselected.
    assign if_gnt   = rst & if_req & (~dm_req | starved);
    assign dm_gnt   = rst & dm_req & ~if_gnt;
    assign dm_rd    = dm_gnt & (dm_we == 4'b0000);
    assign if_stall = if_req & ~if_gnt;
    assign dm_stall = dm_req & ~dm_gnt;

    // NOTE: every combinational output gets a default first, so no path through
    // the block leaves a signal unassigned and infers a latch.
    always_comb begin
        sram_cs  = if_gnt | dm_gnt;
        sram_oe  = if_gnt | dm_rd;
        sram_web = WEB_IDLE;
        sram_a   = '0;
        sram_di  = '0;
        if (if_gnt) begin
            sram_a = if_addr;
        end else if (dm_gnt) begin
            sram_web = ~dm_we;
            sram_a   = dm_addr;
            sram_di  = dm_wdata;
        end
    end

    // State names the owner of the read issued last cycle, i.e. who gets sram_do now.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            kill_q <= 1'b0;
        end else begin
            kill_q <= if_kill;
            if (if_gnt) begin
                state <= S_IRD;
            end else if (dm_rd) begin
                state <= S_DRD;
            end else begin
                state <= S_IDLE;
            end
        end
    end

    // A kill in the issue cycle (kill_q) or the return cycle discards the fetch.
    assign if_rvalid = (state == S_IRD) & ~(kill_q | if_kill);
    assign dm_rvalid = (state == S_DRD);
    assign if_rdata  = if_rvalid ? sram_do : '0;
    assign dm_rdata  = dm_rvalid ? sram_do : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed table, hand sequences and random traffic
// against a behavioural model. Honours SRAM_ARB_STARVE_GUARD_EN the same way as the design.
module tb_sram_port_arbiter;

    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 3;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              if_req, if_kill, if_gnt, if_rvalid, if_stall;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_gnt, dm_rvalid, dm_stall;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_we;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic              sram_cs, sram_oe;
    logic [3:0]        sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [DATA_W-1:0] sram_di, sram_do;

    sram_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_kill   (if_kill),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_addr   (dm_addr),
        .dm_we     (dm_we),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .dm_stall  (dm_stall),
        .sram_cs   (sram_cs),
        .sram_oe   (sram_oe),
        .sram_web  (sram_web),
        .sram_a    (sram_a),
        .sram_di   (sram_di),
        .sram_do   (sram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [13:0] a);
        if (a == 14'h10) return 32'h0000_0013;
        return {2'b10, a, ~a[7:0], a[7:0]};
    endfunction

    // Behavioural SRAM macro: sparse storage over a deterministic background pattern.
    logic [31:0] sram_mem [int];
    logic [31:0] mem_w;
    initial sram_do = '0;
    always @(posedge clk) begin
        if (sram_cs) begin
            mem_w = sram_mem.exists(int'(sram_a)) ? sram_mem[int'(sram_a)] : init_word(sram_a);
            if (sram_oe) sram_do <= mem_w;
            for (int b = 0; b < 4; b++)
                if (!sram_web[b]) mem_w[8*b +: 8] = sram_di[8*b +: 8];
            sram_mem[int'(sram_a)] = mem_w;
        end
    end

    // Reference model state
    int          vectors, miscompares;
    logic [31:0] ref_mem [int];
    int          denied;
    int          pend_owner;     // 0 none, 1 fetch, 2 data
    logic [31:0] pend_data;
    logic        kill_prev;
    logic        m_if_gnt, m_dm_gnt;
    logic        s_if_gnt, s_dm_gnt, s_if_rv, s_dm_rv;
    logic [31:0] s_if_rdata, s_dm_rdata;
    logic [3:0]  s_web;

    function automatic logic [31:0] ref_rd(input logic [13:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        denied     = 0;
        pend_owner = 0;
        pend_data  = '0;
        kill_prev  = 1'b0;
        m_if_gnt   = 1'b0;
        m_dm_gnt   = 1'b0;
    endtask

    // One clock of traffic. Called 1 time unit after a rising edge; returns likewise.
    task automatic step(input logic i_req, input logic [13:0] i_a, input logic kill,
                        input logic d_req, input logic [13:0] d_a, input logic [3:0] we,
                        input logic [31:0] wd);
        logic        e_if, e_dm, e_rd, e_if_rv, e_dm_rv;
        logic [3:0]  e_web;
        logic [13:0] e_a;
        logic [31:0] e_di, w;
        if_req = i_req; if_addr = i_a; if_kill = kill;
        dm_req = d_req; dm_addr = d_a; dm_we = we; dm_wdata = wd;
        #1;
        e_if    = i_req && (!d_req || (GUARD && denied >= STARVE_MAX));
        e_dm    = d_req && !e_if;
        e_rd    = e_if || (e_dm && we == 4'b0000);
        e_web   = e_dm ? ~we : 4'b1111;
        e_a     = e_if ? i_a : (e_dm ? d_a : 14'h0);
        e_di    = e_dm ? wd : 32'h0;
        e_if_rv = (pend_owner == 1) && !(kill_prev || kill);
        e_dm_rv = (pend_owner == 2);
        check("if_gnt",    32'(if_gnt),    32'(e_if));
        check("dm_gnt",    32'(dm_gnt),    32'(e_dm));
        check("if_stall",  32'(if_stall),  32'(i_req && !e_if));
        check("dm_stall",  32'(dm_stall),  32'(d_req && !e_dm));
        check("sram_cs",   32'(sram_cs),   32'(e_if || e_dm));
        check("sram_oe",   32'(sram_oe),   32'(e_rd));
        check("sram_web",  32'(sram_web),  32'(e_web));
        check("sram_a",    32'(sram_a),    32'(e_a));
        check("sram_di",   sram_di,        e_di);
        check("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
        check("if_rdata",  if_rdata,       e_if_rv ? pend_data : 32'h0);
        check("dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
        check("dm_rdata",  dm_rdata,       e_dm_rv ? pend_data : 32'h0);
        s_if_gnt = if_gnt; s_dm_gnt = dm_gnt; s_if_rv = if_rvalid; s_dm_rv = dm_rvalid;
        s_if_rdata = if_rdata; s_dm_rdata = dm_rdata; s_web = sram_web;
        m_if_gnt = e_if; m_dm_gnt = e_dm;
        @(posedge clk);
        pend_data  = e_if ? ref_rd(i_a) : ref_rd(d_a);
        pend_owner = e_if ? 1 : ((e_dm && we == 4'b0000) ? 2 : 0);
        if (e_dm && we != 4'b0000) begin
            w = ref_rd(d_a);
            for (int b = 0; b < 4; b++)
                if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
            ref_mem[int'(d_a)] = w;
        end
        kill_prev = kill;
        denied    = (i_req && !e_if) ? ((denied + 1 > STARVE_MAX) ? STARVE_MAX : denied + 1) : 0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_rvalid"}, 32'(if_rvalid), 32'h0);
        check({tag, "_dm_rvalid"}, 32'(dm_rvalid), 32'h0);
        check({tag, "_if_rdata"},  if_rdata,       32'h0);
        check({tag, "_dm_rdata"},  dm_rdata,       32'h0);
        check({tag, "_sram_cs"},   32'(sram_cs),   32'h0);
        check({tag, "_sram_web"},  32'(sram_web),  32'hF);
    endtask

    typedef struct {
        logic        ireq;
        logic [13:0] ia;
        logic        kill;
        logic        dreq;
        logic [13:0] da;
        logic [3:0]  we;
        logic [31:0] wd;
        logic        x_ig, x_dg, x_irv, x_drv;
    } vec_t;

    function automatic vec_t mk(input logic ireq, input logic [13:0] ia, input logic kill,
                                input logic dreq, input logic [13:0] da, input logic [3:0] we,
                                input logic [31:0] wd, input logic x_ig, input logic x_dg,
                                input logic x_irv, input logic x_drv);
        vec_t v;
        v.ireq = ireq; v.ia = ia; v.kill = kill; v.dreq = dreq; v.da = da; v.we = we; v.wd = wd;
        v.x_ig = x_ig; v.x_dg = x_dg; v.x_irv = x_irv; v.x_drv = x_drv;
        return v;
    endfunction

    vec_t        tbl [12];
    logic [31:0] merged, old30;
    logic        r_ireq, r_kill, r_dreq;
    logic [13:0] r_ia, r_da;
    logic [3:0]  r_we;
    logic [31:0] r_wd;

    initial begin
        vectors = 0; miscompares = 0;
        model_reset();
        if_req = 0; if_addr = '0; if_kill = 0; dm_req = 0; dm_addr = '0; dm_we = '0; dm_wdata = '0;

        // Directed table: {if_req, if_addr, if_kill, dm_req, dm_addr, dm_we, dm_wdata, if_gnt, dm_gnt, if_rvalid, dm_rvalid}
        tbl[0]  = mk(1, 14'h10, 0, 0, 14'h00, 4'b0000, 32'h0,         1, 0, 0, 0);
        tbl[1]  = mk(1, 14'h14, 0, 1, 14'h20, 4'b0000, 32'h0,         0, 1, 1, 0);
        tbl[2]  = mk(1, 14'h14, 0, 0, 14'h00, 4'b0000, 32'h0,         1, 0, 0, 1);
        tbl[3]  = mk(0, 14'h00, 0, 1, 14'h30, 4'b0011, 32'hAABBCCDD,  0, 1, 1, 0);
        tbl[4]  = mk(0, 14'h00, 0, 1, 14'h30, 4'b0000, 32'h0,         0, 1, 0, 0);
        tbl[5]  = mk(0, 14'h00, 0, 0, 14'h00, 4'b0000, 32'h0,         0, 0, 0, 1);
        tbl[6]  = mk(1, 14'h11, 0, 0, 14'h00, 4'b0000, 32'h0,         1, 0, 0, 0);
        tbl[7]  = mk(1, 14'h12, 1, 0, 14'h00, 4'b0000, 32'h0,         1, 0, 0, 0);
        tbl[8]  = mk(0, 14'h00, 0, 0, 14'h00, 4'b0000, 32'h0,         0, 0, 0, 0);
        tbl[9]  = mk(0, 14'h00, 1, 0, 14'h00, 4'b0000, 32'h0,         0, 0, 0, 0);
        tbl[10] = mk(1, 14'h13, 0, 0, 14'h00, 4'b0000, 32'h0,         1, 0, 0, 0);
        tbl[11] = mk(0, 14'h00, 0, 0, 14'h00, 4'b0000, 32'h0,         0, 0, 1, 0);
        old30  = init_word(14'h30);
        merged = {old30[31:16], 16'hCCDD};

        // Reset with both ports requesting: macro must stay idle.
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        check("rst0_if_gnt", 32'(if_gnt), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].ireq, tbl[i].ia, tbl[i].kill, tbl[i].dreq, tbl[i].da, tbl[i].we, tbl[i].wd);
            check($sformatf("tbl%0d_if_gnt", i),    32'(s_if_gnt), 32'(tbl[i].x_ig));
            check($sformatf("tbl%0d_dm_gnt", i),    32'(s_dm_gnt), 32'(tbl[i].x_dg));
            check($sformatf("tbl%0d_if_rvalid", i), 32'(s_if_rv),  32'(tbl[i].x_irv));
            check($sformatf("tbl%0d_dm_rvalid", i), 32'(s_dm_rv),  32'(tbl[i].x_drv));
            if (i == 1) check("fetch_0x10_data", s_if_rdata, 32'h0000_0013);
            if (i == 3) check("write_web",       32'(s_web), 32'h0000_000C);
            if (i == 5) check("merged_read",     s_dm_rdata, merged);
        end

        // Data held for 6 cycles with a waiting fetch, then data drops.
        for (int c = 0; c < 7; c++) begin
            step(1, 14'h40, 0, (c < 6), 14'(14'h20 + c), 4'b0000, 32'h0);
            check($sformatf("starve_c%0d_if_gnt", c), 32'(s_if_gnt),
                  32'((c == 6) || (GUARD && c == 3)));
            check($sformatf("starve_c%0d_dm_gnt", c), 32'(s_dm_gnt),
                  32'((c < 6) && !(GUARD && c == 3)));
        end
        step(0, 0, 0, 0, 0, 4'b0000, 32'h0);

        // Reset asserted while a data read is in flight.
        step(0, 0, 0, 1, 14'h20, 4'b0000, 32'h0);
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0, 4'b0000, 32'h0);
        check("post_rst_dm_rvalid", 32'(s_dm_rv), 32'h0);

        // Random traffic; requests are held until the model says they were granted.
        r_ireq = 0; r_dreq = 0; r_ia = '0; r_da = '0; r_we = '0; r_wd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!(r_ireq && !m_if_gnt)) begin
                r_ireq = ($urandom_range(0, 3) != 0);
                r_ia   = 14'($urandom_range(0, 63));
            end
            if (!(r_dreq && !m_dm_gnt)) begin
                r_dreq = ($urandom_range(0, 2) != 0);
                r_da   = 14'($urandom_range(0, 63));
                r_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
                r_wd   = $urandom;
            end
            r_kill = ($urandom_range(0, 7) == 0);
            step(r_ireq, r_ia, r_kill, r_dreq, r_da, r_we, r_wd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Single-port SRAM arbiter that shares one `SRAM_wrapper` instance between the pipeline's instruction-fetch port (IF stage) and data port (MEM stage). It sits between the two pipeline stages and the macro, and is used in place of separate IM/DM instances. Each cycle it grants at most one access and returns read data one cycle later with an owner-tagged valid. It drives per-port stall signals into the hazard logic.

## Interface
- `ADDR_W`, 14: word address width; maps to byte address bits [15:2].
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 3: consecutive denied IF cycles before IF is forced a grant (range 1–15).
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock; asynchronous, active-low.
- `if_req`  in  1  fetch request; held with `if_addr` until granted.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_kill`  in  1  branch/jump flush; discards the in-flight fetch result.
- `if_gnt`  out  1  fetch issued to the SRAM this cycle (combinational).
- `if_rvalid`  out  1  `if_rdata` is valid this cycle.
- `if_rdata`  out  DATA_W  fetched instruction.
- `if_stall`  out  1  `if_req & ~if_gnt`.
- `dm_req`  in  1  data request; held with `dm_addr`, `dm_we`, `dm_wdata` until granted.
- `dm_addr`  in  ADDR_W  data word address.
- `dm_we`  in  4  active-high byte write enables; 0 means read.
- `dm_wdata`  in  DATA_W  store data.
- `dm_gnt`  out  1  data access issued this cycle.
- `dm_rvalid`  out  1  load data valid (reads only).
- `dm_rdata`  out  DATA_W  load data.
- `dm_stall`  out  1  `dm_req & ~dm_gnt`.
- `sram_cs`, `sram_oe`  out  1  macro chip select and output enable.
- `sram_web`  out  4  macro active-low byte write enables.
- `sram_a`  out  ADDR_W  macro address.
- `sram_di`  out  DATA_W  macro write data.
- `sram_do`  in  DATA_W  macro read data, valid one cycle after a read issue.

## Operation
- Grant, combinational each cycle:
  - Data wins by default.
  - IF wins if `dm_req` is low.
  - IF also wins if `starve_cnt == STARVE_MAX` and `if_req` is high.
  - At most one `*_gnt` is high in any cycle.
- Issue: the granted port's address and controls drive the macro.
  - `sram_cs = if_gnt | dm_gnt`.
  - `sram_oe = 1` for any read.
  - `sram_web = ~dm_we` for data and `4'b1111` for IF.
  - With no grant, `sram_web = 4'b1111`, and `sram_a` and `sram_di` are 0.
- Return FSM: the state records the owner of the previous cycle's read. States are S_IDLE, S_IRD and S_DRD.
  - Next state is S_IRD on an IF grant.
  - Next state is S_DRD on a data read grant (`dm_we == 0`).
  - Otherwise next state is S_IDLE, including for a data write.
- Return outputs:
  - In S_IRD, `if_rvalid = ~kill_q`, where `kill_q` is the registered `if_kill`, OR'd with a same-cycle `if_kill`.
  - In S_DRD, `dm_rvalid = 1`.
  - `*_rdata = sram_do` when the matching valid is high, else 0.
- `starve_cnt` (4 bits):
  - Increments on any cycle with `if_req & ~if_gnt`, saturating at STARVE_MAX.
  - Clears to 0 on `if_gnt` or when `if_req` is low.
- `if_kill` while no fetch is in flight has no effect. A fetch granted in the same cycle as `if_kill` still issues; its result is discarded.

## Timing
- Reset (`rst` low) forces:
  - state to S_IDLE, `starve_cnt` to 0 and `kill_q` to 0;
  - all valids to 0 and all rdata to 0;
  - `sram_cs` to 0 and `sram_web` to 4'b1111.
- Reset asserted mid-access drops the pending return; no valid follows reset release.
- Read latency is exactly 1 cycle from grant to `*_rvalid`. Back-to-back grants give one return per cycle.
- A write completes in its grant cycle. A read of the same address in the next cycle returns the new data.
- Simultaneous `if_req` and `dm_req` with `starve_cnt < STARVE_MAX`: data is granted and IF stalls.

## Configuration
- `SRAM_ARB_STARVE_GUARD_EN` defined: the starvation counter and forced IF grant are present as described.
- Undefined: no counter; strict data priority. IF is granted only when `dm_req` is low.

## Structure
- Shared package `sram_arb_pkg`:
  - `typedef enum logic [1:0] {S_IDLE, S_IRD, S_DRD} arb_state_t`;
  - constant `WEB_IDLE = 4'b1111`.
- One natural sub-module is `sram_arb_starve_cnt`, the saturating counter, instantiated only under the macro.

## Test plan
- Reset, then `if_req` alone at addr 0x10 with SRAM word 0x00000013 → `if_gnt` in cycle 0; `if_rvalid` with rdata 0x00000013 in cycle 1.
- Both requesting, data read at 0x20 → `dm_gnt=1`, `if_gnt=0`, `if_stall=1`; `dm_rvalid` next cycle.
- `dm_req` held high for 6 cycles plus `if_req`, with the guard enabled and STARVE_MAX=3 → IF granted in cycle 3 only; data in all other cycles.
- Same stimulus with the macro undefined → IF never granted until `dm_req` drops.
- Data write `dm_we=4'b0011`, wdata 0xAABBCCDD at 0x30, then a read of 0x30 → `sram_web=4'b1100` on the write; the read returns 0x????CCDD merged with the old upper half.
- IF grant, then `if_kill` in the next cycle → `if_rvalid` stays 0. Also: `rst` low during S_DRD → `dm_rvalid` is 0 and the outputs are at reset values.
